// File: rtl/uart_sched_pkg.sv
// ----------------------------------------------------------------------------
// uart_sched_pkg
// Shared types and constants for the UART word scheduler slice.
//   sched_state_t      : scheduler FSM states (IDLE, SEND, WAIT, TERM)
//   TERM_BYTE          : byte appended after every word when the terminator
//                        build option (UART_SCHED_TERM_EN) is enabled
//   DEFAULT_FRAME_BITS : start + 8 data + stop
//   clog2_min1()       : index width helper that never returns 0
// ----------------------------------------------------------------------------
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        TERM = 2'd3
    } sched_state_t;

    localparam logic [7:0] TERM_BYTE          = 8'h0A;
    localparam int         DEFAULT_FRAME_BITS = 10;

    // Width of an index into n items; a single item still gets a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The winner is the first asserted
// request found searching upward from last+1, wrapping modulo N. The caller
// owns the pointer register.
// Ports:
//   req     [N-1:0]  : request vector
//   last    [IW-1:0] : index of the previous winner
//   gnt     [N-1:0]  : one-hot grant (all zero when no request)
//   gnt_idx [IW-1:0] : index of the granted requester (0 when no request)
// ----------------------------------------------------------------------------
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        int   cand;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Offsets 1..N visit every requester once, ending at 'last' itself.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && req[IW'(cand)]) begin
                found            = 1'b1;
                gnt[IW'(cand)]   = 1'b1;
                gnt_idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_word_scheduler.sv
// ----------------------------------------------------------------------------
// uart_word_scheduler
// Shares one UART transmitter between several word producers. A round-robin
// arbiter picks one valid requester while idle; the accepted word is sent
// most significant byte first, one transmitter frame per byte, paced by an
// internal frame timer of CLKS_PER_BIT*FRAME_BITS cycles.
//
// Build option: define UART_SCHED_TERM_EN to append TERM_BYTE (0x0A) as an
// extra frame after the last data byte of every word.
//
// Ports:
//   clk          : clock, rising edge
//   i_reset_n    : asynchronous active-low reset (aborts any word in flight)
//   i_req_valid  : per-requester valid
//   i_req_data   : requester r word at [r*WORD_BYTES*8 +: WORD_BYTES*8]
//   o_req_ready  : one-hot accept, combinational, only while idle
//   o_start_uart : one-cycle pulse to the transmitter start input
//   o_uart_data  : registered byte to the transmitter, held between pulses
//   o_busy       : high whenever a word is in flight
//   o_grant_id   : requester whose word is in flight
// ----------------------------------------------------------------------------
module uart_word_scheduler
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ      = 2,
    parameter  int WORD_BYTES   = 4,
    parameter  int CLKS_PER_BIT = 868,
    parameter  int FRAME_BITS   = DEFAULT_FRAME_BITS,
    localparam int ID_W         = clog2_min1(NUM_REQ),
    localparam int WORD_W       = WORD_BYTES * 8
) (
    input  logic                      clk,
    input  logic                      i_reset_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_start_uart,
    output logic [7:0]                o_uart_data,
    output logic                      o_busy,
    output logic [ID_W-1:0]           o_grant_id
);

    localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
    localparam int TMR_W      = clog2_min1(FRAME_CLKS);
    localparam int BI_W       = clog2_min1(WORD_BYTES);

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(FRAME_CLKS - 1);
    localparam logic [BI_W-1:0]  LAST_BYTE  = BI_W'(WORD_BYTES - 1);

    sched_state_t      state;
    sched_state_t      next_state;
    logic [ID_W-1:0]   last_q;
    logic [TMR_W-1:0]  timer_q;
    logic [BI_W-1:0]   byte_idx_q;
    logic [WORD_W-1:0] word_q;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]   arb_idx;
    logic              accept;
    logic              timer_done;
    logic              load_frame;
    logic [7:0]        next_byte;
`ifdef UART_SCHED_TERM_EN
    logic              term_sent_q;
`endif

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req     (i_req_valid),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign accept     = (state == IDLE) && (|i_req_valid);
    assign timer_done = (timer_q == '0);
    // Every entry into a frame-emitting state reloads the timer and the byte.
    assign load_frame = (next_state == SEND) || (next_state == TERM);

    // State register
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (|i_req_valid) next_state = SEND;
            end
            SEND: next_state = WAIT;
            WAIT: begin
                if (timer_done) begin
                    if (byte_idx_q != LAST_BYTE) next_state = SEND;
`ifdef UART_SCHED_TERM_EN
                    else if (!term_sent_q)       next_state = TERM;
`endif
                    else                         next_state = IDLE;
                end
            end
`ifdef UART_SCHED_TERM_EN
            TERM: next_state = WAIT;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Byte to present with the next start pulse. From IDLE it comes straight
    // off the winner's input bus because the word register is loaded on the
    // same edge.
    always_comb begin
        int nb;
        next_byte = '0;
        nb        = 0;
        if (state == IDLE) begin
            next_byte = i_req_data[int'(arb_idx)*WORD_W + (WORD_W-8) +: 8];
        end else if (next_state == SEND) begin
            nb = int'(byte_idx_q) + 1;
            if (nb > WORD_BYTES - 1) nb = WORD_BYTES - 1;
            next_byte = word_q[(WORD_BYTES-1-nb)*8 +: 8];
        end
`ifdef UART_SCHED_TERM_EN
        else if (next_state == TERM) begin
            next_byte = TERM_BYTE;
        end
`endif
    end

    // Control and datapath registers that must clear on reset
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_q      <= ID_W'(NUM_REQ - 1);
            o_grant_id  <= '0;
            byte_idx_q  <= '0;
            timer_q     <= '0;
            o_uart_data <= '0;
`ifdef UART_SCHED_TERM_EN
            term_sent_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                last_q      <= arb_idx;
                o_grant_id  <= arb_idx;
                byte_idx_q  <= '0;
`ifdef UART_SCHED_TERM_EN
                term_sent_q <= 1'b0;
`endif
            end else if ((state == WAIT) && (next_state == SEND)) begin
                byte_idx_q <= byte_idx_q + BI_W'(1);
            end

`ifdef UART_SCHED_TERM_EN
            if (state == TERM) term_sent_q <= 1'b1;
`endif

            // Timer counts through the emitting cycle itself, so consecutive
            // start pulses are exactly FRAME_CLKS apart.
            if (load_frame) begin
                timer_q     <= TMR_RELOAD;
                o_uart_data <= next_byte;
            end else if (!timer_done) begin
                timer_q <= timer_q - TMR_W'(1);
            end
        end
    end

    // Word capture; content is only meaningful after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= i_req_data[int'(arb_idx)*WORD_W +: WORD_W];
        end
    end

    // Output logic
    always_comb begin
        o_start_uart = (state == SEND) || (state == TERM);
        o_busy       = (state != IDLE);
        o_req_ready  = '0;
        // Gated by reset so ready stays low while reset is held.
        if ((state == IDLE) && i_reset_n) o_req_ready = arb_gnt;
    end

endmodule

// File: doc/uart_word_scheduler.md
# uart_word_scheduler

Shares the single `uart_transmitter` between several word producers, such as the counter value and status/debug sources, in the up-counter design. Requesters offer fixed-width words through a valid/ready handshake, and a round-robin arbiter picks one. The scheduler serializes the chosen word most significant byte first and paces the transmitter's `i_start_transmission` / `i_data` inputs with an internal frame timer. It sits on the `clk_gen` clock domain, between the producers and `uart_transmitter`.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 1..8.
- `WORD_BYTES`, default 4: bytes per word, range 1..8.
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit. This must match the transmitter.
- `FRAME_BITS`, default 10: bits per UART frame (start + 8 data + stop).
- `clk` input, 1 bit: single clock. Everything is rising-edge.
- `i_reset_n` input, 1 bit: asynchronous, active-low reset.
- `i_req_valid` input, `NUM_REQ` bits: requester r offers a word.
- `i_req_data` input, `NUM_REQ*WORD_BYTES*8` bits: requester r's word is at `[r*WORD_BYTES*8 +: WORD_BYTES*8]`.
- `o_req_ready` output, `NUM_REQ` bits: one-hot, combinational. A word is accepted when `valid & ready`.
- `o_start_uart` output, 1 bit: one-cycle pulse to the transmitter's `i_start_transmission`.
- `o_uart_data` output, 8 bits: byte to the transmitter's `i_data`. Held stable from the start pulse until the next start pulse.
- `o_busy` output, 1 bit: high in every state except IDLE.
- `o_grant_id` output, `$clog2(NUM_REQ)` bits (minimum 1): index of the requester whose word is in flight.

## Operation
- Reset values: state IDLE, `o_start_uart`=0, `o_uart_data`=0, `o_busy`=0, `o_grant_id`=0, `o_req_ready`=0, round-robin pointer `last`=`NUM_REQ-1` (so requester 0 wins first), frame timer=0, byte index=0.
- IDLE:
  - If any `i_req_valid` bit is set, the winner is the first set bit searching from `last+1`, wrapping modulo `NUM_REQ`.
  - `o_req_ready` is asserted for the winner only, in the same cycle.
  - On the edge: capture the word, set `last`=winner, set `o_grant_id`=winner, set byte index=0, go to SEND.
- SEND (1 cycle):
  - `o_uart_data` = byte[index], counted MSB-first. Byte 0 is bits `[WORD_BYTES*8-1 -: 8]`.
  - `o_start_uart`=1.
  - Timer loads `CLKS_PER_BIT*FRAME_BITS-1`. Go to WAIT.
- WAIT:
  - The timer decrements every cycle.
  - At timer 0:
    - If index < `WORD_BYTES-1`: increment index, go to SEND.
    - Otherwise, if the terminator is enabled and has not been sent yet: go to TERM.
    - Otherwise: go to IDLE.
- TERM (1 cycle, only with the macro defined): `o_uart_data`=`TERM_BYTE`, `o_start_uart`=1, timer reloads, mark the terminator as sent, go to WAIT.
- `o_req_ready` is never asserted outside IDLE.
- Requesters must hold `i_req_data` stable while `valid & !ready`. A requester may drop `valid` before it is granted, with no side effects.
- Simultaneous requests: exactly one grant per IDLE cycle. Under sustained load every requester is served within `NUM_REQ` words.
- An asserted reset mid-word aborts the word immediately: outputs go to their reset values and the partially sent word is lost. The transmitter shares the same reset.

## Timing
- Word accepted at edge T0. Byte k start pulse is in cycle T0+1+k·F, where F=`CLKS_PER_BIT*FRAME_BITS`.
- Return to IDLE at T0+1+B·F, where B is the byte count including the terminator.
- Back-to-back words: the next grant happens in that same IDLE cycle, so the inter-word gap is 1 cycle and inter-byte spacing is exactly F.
- `o_start_uart` is never high on two consecutive cycles.
- `o_uart_data` is registered and valid in the cycle `o_start_uart` is high.

## Configuration
- `UART_SCHED_TERM_EN`:
  - Defined: after the last data byte of every word, send `TERM_BYTE` (0x0A) as an extra frame. B = `WORD_BYTES+1`. The TERM state exists.
  - Undefined: no terminator is sent. B = `WORD_BYTES`. The TERM state and terminator flag are not compiled.

## Structure
- Package `uart_sched_pkg` holds:
  - the state enum `sched_state_t` (IDLE, SEND, WAIT, TERM);
  - `TERM_BYTE` = 8'h0A;
  - `DEFAULT_FRAME_BITS` = 10.
- Sub-module `rr_arbiter` (parameter `N`; inputs `req`, `last`; outputs one-hot `gnt` and `gnt_idx`) is purely combinational. The scheduler owns the pointer register.

## Test plan
- Test parameters: `CLKS_PER_BIT`=4, `FRAME_BITS`=10, so F=40.
- Single word: requester 0 presents 0x12345678 with the macro off. Expect `ready` on the acceptance cycle, then start pulses at +1, +41, +81, +121 with data 0x12, 0x34, 0x56, 0x78. `o_busy` falls at +161.
- Contention: both requesters are held valid continuously. Expect grants in the order 0, 1, 0, 1, with a 1-cycle IDLE gap between words.
- Macro on: one word 0xDEADBEEF. Expect five frames, DE AD BE EF 0A, 40 cycles apart.
- Withdrawal: requester 1 raises `valid` during requester 0's word and drops it before the return to IDLE. Expect no grant to requester 1 and `o_busy` low after the word.
- Reset mid-word: assert `i_reset_n`=0 during byte 2's WAIT. Expect all outputs at reset values immediately, and after release the next grant goes to requester 0.
- `NUM_REQ`=1, `WORD_BYTES`=1: consecutive words 0xA5 and 0x5A give start pulses exactly 41 cycles apart.
